int_div_unit: RTL and testbench

Multi-cycle RV32M integer divide/remainder unit serving the execute stage as a request/response responder. The pipeline issues DIV/DIVU/REM/REMU with operands and destination register; the unit computes one quotient bit per cycle and returns the result with its rd tag to the writeback arbiter under the DIVU priority slot. It holds one operation at a time and supports pipeline flush.

---
 rtl/int_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_int_div_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_div_unit.sv
// RV32M DIV/DIVU/REM/REMU responder, restoring radix-2, one quotient bit per cycle; 33 cycles normal, 1 cycle for special cases.
// Single op in flight; the response is held in DONE until resp_ready_i.
// INT_DIV_EARLY_OUT_EN short-circuits |dividend| < |divisor| to a 1-cycle response.
module int_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            resp_vld_q, resp_vld_d;

  logic            signed_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, overflow, early_out;
  logic [XLEN:0]   r_shift, r_diff;
  logic            q_bit;
  logic [XLEN-1:0] r_next, quo_next;

  assign req_ready_o  = (state_q == IDLE) & ~flush_i;
  assign resp_valid_o = resp_vld_q;
  assign result_o     = result_q;
  assign rd_o         = rd_q;
  assign busy_o       = (state_q != IDLE);

  // Operand conditioning for acceptance; op_i[0] selects unsigned, op_i[1] selects remainder.
  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & dividend_i[XLEN-1];
    b_neg     = signed_op & divisor_i[XLEN-1];
    a_mag     = a_neg ? -dividend_i : dividend_i;
    b_mag     = b_neg ? -divisor_i : divisor_i;
    div_zero  = (divisor_i == '0);
    overflow  = signed_op & (dividend_i == MIN_NEG) & (divisor_i == '1);
`ifdef INT_DIV_EARLY_OUT_EN
    early_out = ~div_zero & (a_mag < b_mag);
`else
    early_out = 1'b0;
`endif
  end

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
  always_comb begin
    r_shift  = {rem_q, quo_q[XLEN-1]};
    r_diff   = r_shift - {1'b0, dvsr_q};
    q_bit    = ~r_diff[XLEN];
    r_next   = q_bit ? r_diff[XLEN-1:0] : r_shift[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], q_bit};
  end

  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    is_rem_d   = is_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    rd_d       = rd_q;
    resp_vld_d = resp_vld_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          rd_d     = rd_i;
          is_rem_d = op_i[1];
          if (div_zero) begin
            result_d   = op_i[1] ? dividend_i : '1;
            state_d    = DONE;
            resp_vld_d = 1'b1;
          end else if (overflow) begin
            result_d   = op_i[1] ? '0 : MIN_NEG;
            state_d    = DONE;
            resp_vld_d = 1'b1;
          end else if (early_out) begin
            result_d   = op_i[1] ? dividend_i : '0;
            state_d    = DONE;
            resp_vld_d = 1'b1;
          end else begin
            quo_d     = a_mag;
            rem_d     = '0;
            dvsr_d    = b_mag;
            cnt_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        quo_d = quo_next;
        rem_d = r_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          if (is_rem_q) result_d = neg_rem_q ? -r_next : r_next;
          else          result_d = neg_quo_q ? -quo_next : quo_next;
          state_d    = DONE;
          resp_vld_d = 1'b1;
        end
      end
      DONE: begin
        if (resp_ready_i) begin
          state_d    = IDLE;
          resp_vld_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        resp_vld_d = 1'b0;
      end
    endcase

    // Flush wins over everything, including a response that would complete this cycle.
    if (flush_i) begin
      state_d    = IDLE;
      resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
      resp_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      is_rem_q   <= is_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      resp_vld_q <= resp_vld_d;
    end
  end

endmodule

// File: tb/tb_int_div_unit.sv
// Scoreboard bench for int_div_unit: expectations queued at issue, compared on response.
module tb_int_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        busy_o;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] exp_res_q[$];
  logic [4:0]  exp_rd_q[$];
  int          exp_lat_q[$];

  always #5 clk = ~clk;

  int_div_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_i         (op_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .rd_i         (rd_i),
    .flush_i      (flush_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .result_o     (result_o),
    .rd_o         (rd_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!op[0] && a[31]) ? (32'd0 - a) : a;
    mb = (!op[0] && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef INT_DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the acceptance edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    rd_i        = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold);
    int lat;
    logic [31:0] held_res;
    resp_ready_i = (hold == 0);
    exp_res_q.push_back(model_result(op, a, b));
    exp_rd_q.push_back(rd);
    exp_lat_q.push_back(model_lat(op, a, b));
    send(op, a, b, rd);
    lat = 1;
    while (!resp_valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat_q.pop_front());
    chk("result", result_o, exp_res_q.pop_front());
    chk("rd_tag", {27'd0, rd_o}, {27'd0, exp_rd_q.pop_front()});
    held_res = result_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("held_result", result_o, held_res);
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("post_hs_busy", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid_o}, 32'd0);
    chk({tag, "_result"}, result_o, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vld_seen;
    logic [31:0] ra, rb;
    reset_n      = 1'b0;
    req_valid_i  = 1'b0;
    op_i         = 2'b00;
    dividend_i   = '0;
    divisor_i    = '0;
    rd_i         = '0;
    flush_i      = 1'b0;
    resp_ready_i = 1'b1;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(OP_DIVU, 32'd100, 32'd7, 5'd3, 0);
    do_op(OP_REMU, 32'd100, 32'd7, 5'd4, 0);
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd5, 0);
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    do_op(OP_DIV,  32'h0000_1234, 32'd0, 5'd7, 0);
    do_op(OP_REMU, 32'h0000_1234, 32'd0, 5'd8, 0);
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    do_op(OP_DIV,  32'd20, 32'hFFFF_FFFD, 5'd11, 0);
    do_op(OP_REM,  32'd20, 32'hFFFF_FFFD, 5'd12, 0);
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'd16, 5'd13, 0);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd14, 0);
    do_op(OP_DIV,  32'h8000_0000, 32'd1, 5'd15, 0);

    // Flush mid-calculation: the op vanishes and the unit idles.
    send(OP_DIVU, 32'd1000, 32'd3, 5'd20);
    repeat (9) @(negedge clk);
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    #1;
    chk("flush_req_ready", {31'd0, req_ready_o}, 32'd0);
    @(negedge clk);
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_valid", {31'd0, resp_valid_o}, 32'd0);
    vld_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid_o) vld_seen++;
    end
    chk("flush_no_resp", vld_seen, 0);
    do_op(OP_DIVU, 32'd9, 32'd3, 5'd21, 0);

    // Backpressure: response held for five cycles.
    do_op(OP_DIVU, 32'd5, 32'd10, 5'd22, 5);
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd100, 5'd23, 3);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 5000);
      do_op(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)), 0);
    end

    // Reset in the middle of a calculation.
    send(OP_DIVU, 32'd12345, 32'd11, 5'd30);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("postreset");
    do_op(OP_DIVU, 32'd12345, 32'd11, 5'd31, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
